ram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported system RAM. It shares the RAM between the CPU memory port (requester 0) and a DMA/IO engine (requester 1). It accepts one transaction at a time, drives the RAM address/data/enable lines, waits out the RAM read latency, and returns read data with a one-cycle completion strobe. It sits between the requesters and the RAM model, in place of a direct CPU-to-RAM connection.

---
 rtl/ram_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Purpose: two-requester arbiter/sequencer for the single-ported system RAM (CPU = 0, DMA = 1).
// Latency: gnt one cycle after the request is sampled; write done +1 cycle, read done +RD_LAT+1 cycles after gnt.
// Backpressure: one transaction at a time; requests are only evaluated in IDLE, otherwise they are held off.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req, we               per-requester request and write qualifier (bit 0 = CPU, bit 1 = DMA)
//   addr0/1, wdata0/1     per-requester address and write data
//   gnt, done             one-hot single-cycle accept / completion pulses
//   rdata                 read data, valid in the done cycle and held until the next read completes
//   busy                  high whenever the sequencer is not idle
//   ram_en/we/addr/wdata  RAM command lines; ram_rdata returns RD_LAT cycles after ram_en
module ram_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] we,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       ram_en,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t     state;
    logic       last;    // winner of the most recent grant
    logic       sel;     // winner of the transaction in flight
    logic       txn_we;
    logic [1:0] cnt;
    logic       win;

    // Contention goes to whoever did not win last time.
    always_comb begin
        win = 1'b0;
        if (req == 2'b11)
            win = ~last;
        else
            win = req[1];
    end

    // ram_addr / ram_wdata double as the transaction address/data latches,
    // so they stay stable for the whole transaction and beyond.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            sel       <= 1'b0;
            txn_we    <= 1'b0;
            cnt       <= 2'd0;
            gnt       <= 2'b00;
            done      <= 2'b00;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 8'h00;
            ram_wdata <= 8'h00;
            rdata     <= 8'h00;
        end else begin
            gnt    <= 2'b00;
            done   <= 2'b00;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel       <= win;
                        last      <= win;
                        txn_we    <= we[win];
                        ram_addr  <= win ? addr1 : addr0;
                        ram_wdata <= win ? wdata1 : wdata0;
                        gnt       <= win ? 2'b10 : 2'b01;
                        ram_en    <= 1'b1;
                        ram_we    <= we[win];
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (txn_we) begin
                        done  <= sel ? 2'b10 : 2'b01;
                        state <= DONE;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // cnt reaches zero on the cycle ram_rdata becomes valid.
                    if (cnt == 2'd0) begin
                        rdata <= ram_rdata;
                        done  <= sel ? 2'b10 : 2'b01;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req, we;
    logic [7:0] addr0, addr1, wdata0, wdata1;

    wire [1:0] gnt_a       [4];
    wire [1:0] done_a      [4];
    wire [7:0] rdata_a     [4];
    wire       busy_a      [4];
    wire       ram_en_a    [4];
    wire       ram_we_a    [4];
    wire [7:0] ram_addr_a  [4];
    wire [7:0] ram_wdata_a [4];
    wire [7:0] ram_rdata_a [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // One arbiter per legal read latency, each with its own RAM model.
    // Read data is only valid in the single cycle RD_LAT after ram_en; otherwise 8'hEE.
    for (genvar g = 0; g < 4; g++) begin : lane
        logic [7:0] mem [256];
        logic [7:0] rdq [4];
        always @(posedge clk) begin
            if (ram_en_a[g] && ram_we_a[g])
                mem[ram_addr_a[g]] <= ram_wdata_a[g];
            rdq[0] <= (ram_en_a[g] && !ram_we_a[g]) ? mem[ram_addr_a[g]] : 8'hEE;
            for (int i = 1; i < 4; i++)
                rdq[i] <= rdq[i-1];
        end
        assign ram_rdata_a[g] = rdq[g];

        ram_arbiter #(.RD_LAT(g + 1)) dut (
            .clk       (clk),
            .reset     (reset),
            .req       (req),
            .we        (we),
            .addr0     (addr0),
            .addr1     (addr1),
            .wdata0    (wdata0),
            .wdata1    (wdata1),
            .gnt       (gnt_a[g]),
            .done      (done_a[g]),
            .rdata     (rdata_a[g]),
            .busy      (busy_a[g]),
            .ram_en    (ram_en_a[g]),
            .ram_we    (ram_we_a[g]),
            .ram_addr  (ram_addr_a[g]),
            .ram_wdata (ram_wdata_a[g]),
            .ram_rdata (ram_rdata_a[g])
        );
    end

    typedef struct packed {
        logic [1:0] req;
        logic [1:0] we;
        logic [7:0] a0;
        logic [7:0] d0;
        logic [7:0] a1;
        logic [7:0] d1;
        logic [1:0] gnt;
        logic [1:0] done;
        logic       busy;
        logic       en;
        logic       rwe;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] rd;
    } vec_t;

    vec_t tv [17];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [7:0] a0,
                         input logic [7:0] d0, input logic [7:0] a1, input logic [7:0] d1);
        req = r; we = w; addr0 = a0; wdata0 = d0; addr1 = a1; wdata1 = d1;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag, input int k);
        chk({tag, " gnt"},   {6'd0, gnt_a[k]},  8'h00);
        chk({tag, " done"},  {6'd0, done_a[k]}, 8'h00);
        chk({tag, " busy"},  {7'd0, busy_a[k]}, 8'h00);
        chk({tag, " en"},    {7'd0, ram_en_a[k]}, 8'h00);
        chk({tag, " rwe"},   {7'd0, ram_we_a[k]}, 8'h00);
        chk({tag, " addr"},  ram_addr_a[k],  8'h00);
        chk({tag, " wdata"}, ram_wdata_a[k], 8'h00);
        chk({tag, " rdata"}, rdata_a[k],     8'h00);
    endtask

    initial begin
        logic [1:0] gseq [4];
        logic [1:0] dseq [4];
        int ng, nd, viol;
        int done_at [4];
        int en_cnt [4];
        logic [7:0] rd_at [4];

        // CPU write/read, DMA write/read, then a write that must not disturb rdata (RD_LAT=1).
        //          req    we     a0     d0     a1     d1     gnt    done   bsy   en    rwe   addr   wd     rd
        tv[0]  = '{2'b01, 2'b01, 8'h10, 8'hA5, 8'h00, 8'h00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 8'h10, 8'hA5, 8'h00};
        tv[1]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 8'h10, 8'hA5, 8'h00};
        tv[2]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h10, 8'hA5, 8'h00};
        tv[3]  = '{2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00};
        tv[4]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00};
        tv[5]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        tv[6]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        tv[7]  = '{2'b10, 2'b10, 8'h00, 8'h00, 8'h20, 8'h77, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 8'h20, 8'h77, 8'hA5};
        tv[8]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 8'h20, 8'h77, 8'hA5};
        tv[9]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h20, 8'h77, 8'hA5};
        tv[10] = '{2'b10, 2'b00, 8'h00, 8'h00, 8'h20, 8'h00, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 8'hA5};
        tv[11] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 8'hA5};
        tv[12] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 8'h77};
        tv[13] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h77};
        tv[14] = '{2'b01, 2'b01, 8'h20, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 8'h20, 8'h00, 8'h77};
        tv[15] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 8'h77};
        tv[16] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h77};

        // Reset state on every lane.
        do_reset();
        for (int k = 0; k < 4; k++)
            chk_all_zero($sformatf("reset lane%0d", k), k);

        // Cycle-by-cycle table on the RD_LAT=1 lane.
        for (int i = 0; i < 17; i++) begin
            drive(tv[i].req, tv[i].we, tv[i].a0, tv[i].d0, tv[i].a1, tv[i].d1);
            tick();
            chk($sformatf("v%0d gnt", i),   {6'd0, gnt_a[0]},    {6'd0, tv[i].gnt});
            chk($sformatf("v%0d done", i),  {6'd0, done_a[0]},   {6'd0, tv[i].done});
            chk($sformatf("v%0d busy", i),  {7'd0, busy_a[0]},   {7'd0, tv[i].busy});
            chk($sformatf("v%0d en", i),    {7'd0, ram_en_a[0]}, {7'd0, tv[i].en});
            chk($sformatf("v%0d rwe", i),   {7'd0, ram_we_a[0]}, {7'd0, tv[i].rwe});
            chk($sformatf("v%0d addr", i),  ram_addr_a[0],  tv[i].addr);
            chk($sformatf("v%0d wdata", i), ram_wdata_a[0], tv[i].wd);
            chk($sformatf("v%0d rdata", i), rdata_a[0],     tv[i].rd);
        end

        // Contention: both reads held high, grants and completions must alternate CPU first.
        do_reset();
        drive(2'b11, 2'b00, 8'h10, 8'h00, 8'h20, 8'h00);
        ng = 0; nd = 0; viol = 0;
        for (int c = 0; c < 40 && nd < 4; c++) begin
            tick();
            if (gnt_a[0] != 2'b00 && done_a[0] != 2'b00) viol++;
            if (gnt_a[0] == 2'b11 || done_a[0] == 2'b11) viol++;
            if (gnt_a[0] != 2'b00 && ng < 4) begin gseq[ng] = gnt_a[0]; ng++; end
            if (done_a[0] != 2'b00) begin dseq[nd] = done_a[0]; nd++; end
        end
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("contention grant count", 8'(ng), 8'd4);
        chk("contention done count", 8'(nd), 8'd4);
        chk("contention overlap", 8'(viol), 8'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("contention gnt%0d", i),  {6'd0, gseq[i]}, (i % 2 == 0) ? 8'h01 : 8'h02);
            chk($sformatf("contention done%0d", i), {6'd0, dseq[i]}, (i % 2 == 0) ? 8'h01 : 8'h02);
        end

        // Latency sweep: DMA writes 8'h3C, then reads it back on every lane at once.
        do_reset();
        drive(2'b10, 2'b10, 8'h00, 8'h00, 8'h30, 8'h3C);
        tick();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(); tick(); tick();
        drive(2'b10, 2'b00, 8'h00, 8'h00, 8'h30, 8'h00);
        tick();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sweep%0d gnt", k + 1), {6'd0, gnt_a[k]}, 8'h02);
            en_cnt[k]  = ram_en_a[k] ? 1 : 0;
            done_at[k] = 0;
            rd_at[k]   = 8'h00;
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (ram_en_a[k]) en_cnt[k]++;
                if (done_a[k][1] && done_at[k] == 0) begin
                    done_at[k] = c;
                    rd_at[k]   = rdata_a[k];
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sweep%0d done offset", k + 1), 8'(done_at[k]), 8'(k + 2));
            chk($sformatf("sweep%0d rdata", k + 1), rd_at[k], 8'h3C);
            chk($sformatf("sweep%0d ram_en cycles", k + 1), 8'(en_cnt[k]), 8'd1);
        end

        // Request during busy (RD_LAT=3 lane): DMA waits for IDLE, then beats a CPU re-request.
        drive(2'b01, 2'b00, 8'h30, 8'h00, 8'h00, 8'h00);
        tick();
        chk("busyreq cpu gnt", {6'd0, gnt_a[2]}, 8'h01);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("busyreq c%0d gnt", c), {6'd0, gnt_a[2]}, (c == 6) ? 8'h02 : 8'h00);
            if (c == 1) drive(2'b10, 2'b00, 8'h00, 8'h00, 8'h30, 8'h00);
            if (c == 4) begin
                chk("busyreq cpu done", {6'd0, done_a[2]}, 8'h01);
                drive(2'b11, 2'b00, 8'h30, 8'h00, 8'h30, 8'h00);
            end
            if (c == 5) chk("busyreq idle busy", {7'd0, busy_a[2]}, 8'h00);
        end
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int c = 0; c < 5; c++) tick();
        chk("busyreq dma rdata", rdata_a[2], 8'h3C);

        // Reset in the second WAIT cycle of a CPU read (RD_LAT=3 lane).
        drive(2'b01, 2'b00, 8'h30, 8'h00, 8'h00, 8'h00);
        tick();
        chk("rstmid cpu gnt", {6'd0, gnt_a[2]}, 8'h01);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_all_zero("rstmid", 2);
        reset = 1'b0;
        viol = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done_a[2] != 2'b00 || busy_a[2] || ram_en_a[2]) viol++;
        end
        chk("rstmid no activity after reset", 8'(viol), 8'd0);
        drive(2'b11, 2'b00, 8'h30, 8'h00, 8'h30, 8'h00);
        tick();
        chk("rstmid first gnt after reset", {6'd0, gnt_a[2]}, 8'h01);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int c = 0; c < 6; c++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
